// File: rtl/game_pkg.sv
// Shared game constants and the one-hot timer state encoding used by game_timer and the game-state FSM.
package game_pkg;

    localparam int MAX_TIME = 120;
    localparam int MIN_W    = 8;
    localparam int MIN_SAT  = 255;

    typedef enum logic [3:0] {
        ST_STOPPED = 4'b0001,
        ST_RUNNING = 4'b0010,
        ST_PAUSED  = 4'b0100,
        ST_EXPIRED = 4'b1000
    } timer_state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Divides Clk by TICKS_PER_MIN while en is high; terminal is combinational, high on the wrapping cycle.
// clr has priority over en; warp makes every enabled cycle terminal and holds the counter at 0.
module tick_prescaler #(
    parameter int TICKS_PER_MIN = 100_000_000,
    parameter int PRESCALE_W    = 27
) (
    input  logic Clk,
    input  logic Reset,
    input  logic en,
    input  logic clr,
    input  logic warp,
    output logic terminal
);

    localparam logic [PRESCALE_W-1:0] LAST = PRESCALE_W'(TICKS_PER_MIN - 1);

    logic [PRESCALE_W-1:0] cnt_q, cnt_d;

    assign terminal = en & (warp | (cnt_q == LAST));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = terminal ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/game_timer.sv
// Game-minute clock: saturating minutes count, one-cycle min_tick per increment, registered time_up; no backpressure.
// Optional GAME_TIMER_WARP_EN adds the Warp input (one minute per enabled cycle).
module game_timer
    import game_pkg::*;
#(
    parameter int TICKS_PER_MIN = 100_000_000,
    parameter int PRESCALE_W    = 27
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Clear,
    input  logic             Pause,
`ifdef GAME_TIMER_WARP_EN
    input  logic             Warp,
`endif
    output logic [MIN_W-1:0] minutes,
    output logic             min_tick,
    output logic             time_up,
    output logic             running
);

    timer_state_e     state_q, state_d;
    logic [MIN_W-1:0] minutes_q, minutes_d;
    logic             min_tick_q, min_tick_d;
    logic             time_up_q, time_up_d;
    logic             warp;
    logic             count_en;
    logic             terminal;

`ifdef GAME_TIMER_WARP_EN
    assign warp = Warp;
`else
    assign warp = 1'b0;
`endif

    // Clear/Start win over a coincident terminal count, so they also mask the enable.
    assign count_en = (state_q == ST_RUNNING) & ~Pause & ~Clear & ~Start;

    tick_prescaler #(
        .TICKS_PER_MIN (TICKS_PER_MIN),
        .PRESCALE_W    (PRESCALE_W)
    ) u_prescaler (
        .Clk      (Clk),
        .Reset    (Reset),
        .en       (count_en),
        .clr      (Clear | Start),
        .warp     (warp),
        .terminal (terminal)
    );

    always_comb begin
        state_d    = state_q;
        minutes_d  = minutes_q;
        min_tick_d = 1'b0;
        if (Clear) begin
            state_d   = ST_STOPPED;
            minutes_d = '0;
        end else if (Start) begin
            state_d   = ST_RUNNING;
            minutes_d = '0;
        end else begin
            case (state_q)
                ST_RUNNING: begin
                    if (Pause) begin
                        state_d = ST_PAUSED;
                    end else if (terminal && (minutes_q != MIN_W'(MIN_SAT))) begin
                        minutes_d  = minutes_q + 1'b1;
                        min_tick_d = 1'b1;
                        if (minutes_q == MIN_W'(MIN_SAT - 1)) begin
                            state_d = ST_EXPIRED;
                        end
                    end
                end
                ST_PAUSED: begin
                    if (!Pause) begin
                        state_d = ST_RUNNING;
                    end
                end
                default: begin
                end
            endcase
        end
        time_up_d = (minutes_d >= MIN_W'(MAX_TIME));
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= ST_STOPPED;
            minutes_q  <= '0;
            min_tick_q <= 1'b0;
            time_up_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            minutes_q  <= minutes_d;
            min_tick_q <= min_tick_d;
            time_up_q  <= time_up_d;
        end
    end

    assign minutes  = minutes_q;
    assign min_tick = min_tick_q;
    assign time_up  = time_up_q;
    assign running  = (state_q == ST_RUNNING);

endmodule

// File: tb/tb_game_timer.sv
// Bench for game_timer at TICKS_PER_MIN = 4; expected min_tick events are queued by stimulus and checked by a monitor.
module tb_game_timer;

    logic       Clk   = 1'b0;
    logic       Reset = 1'b0;
    logic       Start = 1'b0;
    logic       Clear = 1'b0;
    logic       Pause = 1'b0;
`ifdef GAME_TIMER_WARP_EN
    logic       Warp  = 1'b0;
`endif
    logic [7:0] minutes;
    logic       min_tick;
    logic       time_up;
    logic       running;

    int cyc      = 0;
    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int mins;
        int at;
        int tu;
    } exp_t;

    exp_t sb[$];

    game_timer #(
        .TICKS_PER_MIN (4),
        .PRESCALE_W    (3)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Start    (Start),
        .Clear    (Clear),
        .Pause    (Pause),
`ifdef GAME_TIMER_WARP_EN
        .Warp     (Warp),
`endif
        .minutes  (minutes),
        .min_tick (min_tick),
        .time_up  (time_up),
        .running  (running)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic goto(input int t);
        while (cyc < t) @(negedge Clk);
    endtask

    task automatic push(input int m, input int t);
        exp_t e;
        e.mins = m;
        e.at   = t;
        e.tu   = (m >= 120) ? 1 : 0;
        sb.push_back(e);
    endtask

    // Returns the edge number at which Start is sampled.
    task automatic pulse_start(output int n);
        Start = 1'b1;
        n = cyc + 1;
        @(negedge Clk);
        Start = 1'b0;
    endtask

    task automatic pulse_clear();
        Clear = 1'b1;
        @(negedge Clk);
        Clear = 1'b0;
    endtask

    always @(negedge Clk) begin
        if (Reset && min_tick) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_tick: got tick with minutes=%0d at cycle %0d, expected none", minutes, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("tick_minutes", int'(minutes), e.mins);
                chk("tick_cycle", cyc, e.at);
                chk("tick_time_up", int'(time_up), e.tu);
            end
        end
    end

    initial begin
        #60000;
        n_fail++;
        $display("FAIL watchdog: got timeout at cycle %0d, expected completion", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        // Reset and idle
        repeat (3) @(negedge Clk);
        chk("rst_minutes", int'(minutes), 0);
        chk("rst_running", int'(running), 0);
        chk("rst_time_up", int'(time_up), 0);
        chk("rst_min_tick", int'(min_tick), 0);
        Reset = 1'b1;
        goto(cyc + 20);
        chk("idle_minutes", int'(minutes), 0);
        chk("idle_running", int'(running), 0);

        // Basic counting
        pulse_start(n);
        push(1, n + 4);
        push(2, n + 8);
        push(3, n + 12);
        goto(n + 6);
        chk("run_running", int'(running), 1);
        goto(n + 12);
        chk("basic_minutes", int'(minutes), 3);
        pulse_clear();
        goto(cyc + 8);
        chk("basic_sb_empty", sb.size(), 0);
        chk("cleared_minutes", int'(minutes), 0);

        // Pause for 5 cycles after minutes=2 plus one prescaler count
        pulse_start(n);
        push(1, n + 4);
        push(2, n + 8);
        push(3, n + 18);
        goto(n + 9);
        Pause = 1'b1;
        goto(n + 11);
        chk("paused_running", int'(running), 0);
        goto(n + 14);
        Pause = 1'b0;
        goto(n + 16);
        chk("resumed_running", int'(running), 1);
        goto(n + 20);
        chk("pause_minutes", int'(minutes), 3);
        pulse_clear();
        goto(cyc + 4);
        chk("pause_sb_empty", sb.size(), 0);

        // Long run to MAX_TIME and saturation
        pulse_start(n);
        for (int k = 1; k <= 255; k++) push(k, n + 4 * k);
        goto(n + 479);
        chk("pre_limit_time_up", int'(time_up), 0);
        goto(n + 480);
        chk("limit_minutes", int'(minutes), 120);
        chk("limit_time_up", int'(time_up), 1);
        goto(n + 1020);
        chk("sat_minutes", int'(minutes), 255);
        goto(n + 1040);
        chk("expired_minutes", int'(minutes), 255);
        chk("expired_running", int'(running), 0);
        chk("long_sb_empty", sb.size(), 0);
        pulse_clear();

        // Clear and Start together on a terminal-count edge
        pulse_start(n);
        push(1, n + 4);
        goto(n + 7);
        Clear = 1'b1;
        Start = 1'b1;
        @(negedge Clk);
        Clear = 1'b0;
        Start = 1'b0;
        chk("cs_minutes", int'(minutes), 0);
        chk("cs_min_tick", int'(min_tick), 0);
        chk("cs_running", int'(running), 0);
        goto(n + 20);
        chk("cs_idle_minutes", int'(minutes), 0);
        chk("cs_sb_empty", sb.size(), 0);

        // Asynchronous reset mid-run
        pulse_start(n);
        push(1, n + 4);
        goto(n + 6);
        #2 Reset = 1'b0;
        #1;
        chk("ar_minutes", int'(minutes), 0);
        chk("ar_running", int'(running), 0);
        @(negedge Clk);
        Reset = 1'b1;
        goto(cyc + 10);
        chk("ar_idle_minutes", int'(minutes), 0);
        chk("ar_sb_empty", sb.size(), 0);

`ifdef GAME_TIMER_WARP_EN
        // Warp to MAX_TIME, then resume normal division
        pulse_start(n);
        Warp = 1'b1;
        for (int k = 1; k <= 120; k++) push(k, n + k);
        push(121, n + 124);
        goto(n + 120);
        chk("warp_minutes", int'(minutes), 120);
        chk("warp_time_up", int'(time_up), 1);
        Warp = 1'b0;
        goto(n + 126);
        chk("warp_resume_minutes", int'(minutes), 121);
        pulse_clear();
        goto(cyc + 4);
        chk("warp_sb_empty", sb.size(), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
